_btn_sync_debounce: RTL and testbench
=====================================

Name: _btn_sync_debounce

Overview:
Input-conditioning stage directly upstream of the D flip-flop stage (_dff_r_sync / _dff_r_async and their combined wrapper). It takes a raw, asynchronous, bouncy push-button/switch signal and produces a clean, clock-synchronous level. That level drives the flip-flop stage's d input. It also produces single-cycle rise/fall pulses for counters and FSMs elsewhere in the design. The block has a 2-FF synchronizer, a debounce counter and a 4-state FSM.

Parameters:
DEBOUNCE, 4, number of consecutive clock cycles the synchronized input must hold a new value before it is accepted; legal range 1..2^CNT_WIDTH
CNT_WIDTH, 4, width of the debounce counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
btn_in  input  1  raw external input, asynchronous to clk, may bounce
btn_level  output  1  debounced, synchronized level (feeds downstream d)
btn_rise  output  1  one-cycle pulse when btn_level goes 0->1
btn_fall  output  1  one-cycle pulse when btn_level goes 1->0
busy  output  1  high while a candidate transition is being qualified

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed): sync FFs=0, counter=0, FSM=IDLE_LO, btn_level=0, btn_rise=0, btn_fall=0, busy=0. All outputs are registered or are pure decodes of registered state; none depend combinationally on btn_in.
- Synchronizer: ff1 <= btn_in, ff2 <= ff1. s = ff2. Only s is used by the rest of the block.
- FSM states: IDLE_LO (stable 0), CHK_HI (qualifying 0->1), IDLE_HI (stable 1), CHK_LO (qualifying 1->0).
- IDLE_LO: if s=1 -> CHK_HI, cnt<=0; else stay.
- CHK_HI: if s=0 -> IDLE_LO, cnt<=0 (glitch rejected, no pulse). Else if cnt==DEBOUNCE-1 -> IDLE_HI, btn_level<=1, btn_rise<=1, cnt<=0. Else cnt<=cnt+1.
- IDLE_HI / CHK_LO: mirror of the above with polarities swapped; the CHK_LO->IDLE_HI abort path produces no pulse. Completion sets btn_level<=0 and btn_fall<=1.
- btn_rise/btn_fall are high for exactly one cycle: the cycle after the qualifying edge. They default to 0 on every other edge. They are never both high at once.
- busy = (state==CHK_HI or state==CHK_LO).
- Latency: if btn_in is 1 at rising edge k and stays 1, then btn_level and btn_rise become 1 after edge k+2+DEBOUNCE. The 2 cycles are synchronizer + IDLE detection. The same holds for release.
- Minimum accepted pulse width is DEBOUNCE+1 consecutive samples of s. Any shorter run of s is discarded.
- Counter: unsigned, CNT_WIDTH bits. It never exceeds DEBOUNCE-1 and cannot wrap.
- A bounce during CHK_* restarts qualification from the idle state. There is no partial credit.
- Reset asserted mid-qualification or in IDLE_HI: immediate return to the reset values above. After release, if btn_in is held at 1, the block re-qualifies a rise from scratch (full latency).
- DEBOUNCE=1: a value is accepted after 1 cycle in CHK_*. The latency formula above still holds.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, btn_in=0, release -> all outputs 0 for 20 cycles, busy=0.
- Clean press, DEBOUNCE=4: btn_in 0->1 sampled at edge 10, held -> btn_level=1 after edge 16; btn_rise=1 only in cycle 16-17; btn_fall stays 0; busy=1 only between edges 12 and 16.
- Bounce rejection: after the press, btn_in pulses to 0 for 2 cycles and back to 1 (s low for 2 samples) -> btn_level stays 1, no btn_fall, FSM returns to IDLE_HI.
- Short glitch while low: btn_in=1 for 3 cycles, then 0 -> btn_level stays 0, no btn_rise, busy pulses then clears.
- Release: btn_in 1->0 sampled at edge 40, held -> btn_level=0 after edge 46, btn_fall=1 only in cycle 46-47.
- Reset mid-operation: btn_in held 1, assert reset_n during CHK_HI (cnt=2) asynchronously between edges -> outputs 0 immediately. Release with btn_in still 1 -> btn_rise occurs DEBOUNCE+2 edges after the first post-reset edge that samples btn_in=1.

Source files
------------

// File: rtl/_btn_sync_debounce.sv
// Button/switch input conditioner: 2-FF synchronizer, debounce counter and
// a 4-state qualification FSM producing a clean level plus rise/fall pulses.
module _btn_sync_debounce #(
   parameter int unsigned DEBOUNCE  = 4,
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      CHK_HI  = 2'd1,
      IDLE_HI = 2'd2,
      CHK_LO  = 2'd3
   } state_t;

   // Terminal count: a candidate is accepted when s still holds at this count.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE - 1);

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 s;

   assign s = sync2_q;

   // Next-state logic: synchronizer shift, qualification FSM and counter.
   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE_LO: begin
            if (s) begin
               state_d = CHK_HI;
               cnt_d   = '0;
            end
         end
         CHK_HI: begin
            if (!s) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               level_d = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE_HI: begin
            if (!s) begin
               state_d = CHK_LO;
               cnt_d   = '0;
            end
         end
         CHK_LO: begin
            if (s) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;
   assign btn_fall  = fall_q;
   assign busy      = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule

// File: tb/tb__btn_sync_debounce.sv
// Scoreboard bench for _btn_sync_debounce: stimulus pushes expected rise/fall
// events (kind + edge number); a negedge monitor pops and checks each pulse.
module tb__btn_sync_debounce;

   localparam int unsigned D = 4;

   typedef struct {
      bit          is_rise;
      int unsigned cyc;
   } ev_t;

   logic clk;
   logic reset_n;
   logic btn_in;
   logic btn_level;
   logic btn_rise;
   logic btn_fall;
   logic busy;

   ev_t         exp_q[$];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned k;
   logic        seen;

   _btn_sync_debounce #(.DEBOUNCE(D), .CNT_WIDTH(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_in    (btn_in),
      .btn_level (btn_level),
      .btn_rise  (btn_rise),
      .btn_fall  (btn_fall),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after rising edge n, cyc == n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (reset_n && (btn_rise || btn_fall)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got rise=%0b fall=%0b at cycle %0d, expected none",
                     btn_rise, btn_fall, cyc);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if ((btn_rise !== e.is_rise) || (btn_fall !== !e.is_rise) ||
                (btn_level !== e.is_rise) || (cyc != e.cyc)) begin
               errors++;
               $display("FAIL pulse_event: got rise=%0b fall=%0b level=%0b cycle=%0d, expected rise=%0b fall=%0b level=%0b cycle=%0d",
                        btn_rise, btn_fall, btn_level, cyc,
                        e.is_rise, !e.is_rise, e.is_rise, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      btn_in  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {btn_level, btn_rise, btn_fall, busy}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_outputs", {btn_level, btn_rise, btn_fall, busy}, 32'd0);
      end

      // Clean press
      k = cyc + 1;
      btn_in = 1'b1;
      exp_q.push_back('{1'b1, k + 2 + D});
      for (int j = 0; j < D + 4; j++) begin
         @(negedge clk);
         check("press_busy", busy, (cyc >= k + 2) && (cyc < k + 2 + D));
         check("press_level", btn_level, cyc >= k + 2 + D);
      end

      // Bounce low for 2 samples while high
      btn_in = 1'b0;
      repeat (2) @(negedge clk);
      btn_in = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("bounce_level", btn_level, 32'd1);
      end
      check("bounce_busy_clear", busy, 32'd0);

      // Release
      k = cyc + 1;
      btn_in = 1'b0;
      exp_q.push_back('{1'b0, k + 2 + D});
      for (int j = 0; j < D + 4; j++) begin
         @(negedge clk);
         check("release_busy", busy, (cyc >= k + 2) && (cyc < k + 2 + D));
         check("release_level", btn_level, cyc < k + 2 + D);
      end

      // Short glitch of 3 samples while low
      seen = 1'b0;
      btn_in = 1'b1;
      repeat (3) begin
         @(negedge clk);
         seen |= busy;
      end
      btn_in = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen |= busy;
         check("glitch_level", btn_level, 32'd0);
      end
      check("glitch_busy_seen", seen, 32'd1);
      check("glitch_busy_clear", busy, 32'd0);

      // Exactly DEBOUNCE samples high: rejected
      btn_in = 1'b1;
      repeat (D) @(negedge clk);
      btn_in = 1'b0;
      repeat (D + 4) begin
         @(negedge clk);
         check("dbn_glitch_level", btn_level, 32'd0);
      end
      check("dbn_glitch_busy", busy, 32'd0);

      // DEBOUNCE+1 samples high: minimum accepted pulse, then released
      k = cyc + 1;
      btn_in = 1'b1;
      exp_q.push_back('{1'b1, k + 2 + D});
      repeat (D + 1) @(negedge clk);
      btn_in = 1'b0;
      exp_q.push_back('{1'b0, k + D + 1 + 2 + D});
      repeat (2 * D + 6) @(negedge clk);
      check("min_pulse_level", btn_level, 32'd0);

      // Asynchronous reset during CHK_HI with cnt=2
      k = cyc + 1;
      btn_in = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_busy_before_reset", busy, 32'd1);
      #1 reset_n = 1'b0;
      #1 check("async_reset_outputs", {btn_level, btn_rise, btn_fall, busy}, 32'd0);
      repeat (2) @(negedge clk);
      check("held_reset_outputs", {btn_level, btn_rise, btn_fall, busy}, 32'd0);
      reset_n = 1'b1;
      k = cyc + 1;
      exp_q.push_back('{1'b1, k + 2 + D});
      repeat (D + 6) @(negedge clk);
      check("post_reset_level", btn_level, 32'd1);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
